ppu_sprite_eval_n: RTL and testbench

PPU_SPRITE_EVAL_N -- requirements
Module: ppu_sprite_eval_n

---
 rtl/ppu_sprite_eval_n.sv | 185 ++++++++++++++++++
 tb/tb_ppu_sprite_eval_n.sv | 244 ++++++++++++++++++++++++
 2 files changed

// File: rtl/ppu_sprite_eval_n.sv
// Per-scanline sprite evaluation: scans primary OAM and fills secondary OAM.
// Define PPU_SPR_OVERFLOW_BUG_EN to reproduce the 2C02 diagonal overflow scan.
module ppu_sprite_eval_n #(
    parameter int unsigned MAX_SPRITES = 8,
    localparam int unsigned SEC_BYTES  = MAX_SPRITES * 4,
    localparam int unsigned SEC_AW     = $clog2(SEC_BYTES),
    localparam int unsigned CNT_W      = $clog2(MAX_SPRITES) + 1,
    localparam int unsigned SLOT_W     = CNT_W - 1
) (
    input  logic              clk,
    input  logic              rst,
    input  logic [8:0]        x_i,
    input  logic [8:0]        y_i,
    input  logic              spr_enable_i,
    input  logic              spr_size16_i,
    output logic [7:0]        oam_addr_o,
    input  logic [7:0]        oam_data_i,
    input  logic [7:0]        new_oam_addr_i,
    input  logic              new_oam_addr_w_i,
    input  logic [SEC_AW-1:0] sec_oam_addr_i,
    output logic [7:0]        sec_oam_data_o,
    output logic              overflow_o,
    output logic              slot_0_is_spr_0_o,
    output logic [CNT_W-1:0]  sprite_count_o
);

    typedef enum logic [2:0] {IDLE, CLEAR, FETCH_Y, CHECK_Y, COPY, SCAN, DONE} state_t;

    state_t              state_q;
    logic [7:0]          sec_q [SEC_BYTES];
    logic [SEC_AW-1:0]   clr_idx_q;
    logic [5:0]          n_q;
    logic [1:0]          m_q;
    logic                scan_ph_q;
    logic [CNT_W-1:0]    count_q;
    logic                spr0_q;
    logic [7:0]          oam_addr_q;
    logic                overflow_q;
    logic                slot0_q;
    logic [CNT_W-1:0]    count_out_q;

    logic [8:0]          dy;
    logic                in_range;
    logic [SLOT_W-1:0]   slot;
    logic [5:0]          n_nxt;
    logic                last_spr;
    logic                full_next;
    logic                eval_active;
`ifdef PPU_SPR_OVERFLOW_BUG_EN
    logic [1:0]          m_nxt;
    assign m_nxt = m_q + 2'd1;
`endif

    // Wrapping 9-bit difference makes sprites below the line fall out of range.
    assign dy          = y_i - {1'b0, oam_data_i};
    assign in_range    = dy < (spr_size16_i ? 9'd16 : 9'd8);
    assign slot        = count_q[SLOT_W-1:0];
    assign n_nxt       = n_q + 6'd1;
    assign last_spr    = (n_q == 6'd63);
    assign full_next   = (count_q == CNT_W'(MAX_SPRITES - 1));
    assign eval_active = (state_q != IDLE) && (state_q != DONE);

    assign sec_oam_data_o    = sec_q[sec_oam_addr_i];
    assign oam_addr_o        = oam_addr_q;
    assign overflow_o        = overflow_q;
    assign slot_0_is_spr_0_o = slot0_q;
    assign sprite_count_o    = count_out_q;

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q     <= IDLE;
            for (int unsigned i = 0; i < SEC_BYTES; i++) sec_q[SEC_AW'(i)] <= 8'hFF;
            clr_idx_q   <= '0;
            n_q         <= '0;
            m_q         <= '0;
            scan_ph_q   <= 1'b0;
            count_q     <= '0;
            spr0_q      <= 1'b0;
            oam_addr_q  <= '0;
            overflow_q  <= 1'b0;
            slot0_q     <= 1'b0;
            count_out_q <= '0;
        end else begin
            if (x_i == 9'd257) begin
                count_out_q <= count_q;
                slot0_q     <= spr0_q;
            end

            if (!spr_enable_i) begin
                state_q <= IDLE;
            end else if (eval_active && x_i == 9'd257) begin
                state_q <= DONE;
            end else begin
                unique case (state_q)
                    IDLE: begin
                        if (x_i == 9'd1 && y_i <= 9'd239) begin
                            state_q   <= CLEAR;
                            clr_idx_q <= '0;
                            spr0_q    <= 1'b0;
                        end
                    end
                    CLEAR: begin
                        sec_q[clr_idx_q] <= 8'hFF;
                        clr_idx_q        <= clr_idx_q + SEC_AW'(1);
                        if (x_i == 9'd65) begin
                            state_q    <= FETCH_Y;
                            n_q        <= '0;
                            m_q        <= '0;
                            count_q    <= '0;
                            oam_addr_q <= 8'd0;
                        end
                    end
                    // Address runs one byte ahead so data lines up with the next state.
                    FETCH_Y: begin
                        oam_addr_q <= {n_q, 2'd1};
                        state_q    <= CHECK_Y;
                    end
                    CHECK_Y: begin
                        if (in_range) begin
                            sec_q[{slot, 2'd0}] <= oam_data_i;
                            oam_addr_q          <= {n_q, 2'd2};
                            m_q                 <= 2'd1;
                            state_q             <= COPY;
                        end else if (last_spr) begin
                            state_q <= DONE;
                        end else begin
                            n_q        <= n_nxt;
                            oam_addr_q <= {n_nxt, 2'd0};
                            state_q    <= FETCH_Y;
                        end
                    end
                    COPY: begin
                        sec_q[{slot, m_q}] <= oam_data_i;
                        m_q                <= m_q + 2'd1;
                        oam_addr_q         <= {n_q, 2'd3};
                        if (m_q == 2'd3) begin
                            count_q <= count_q + CNT_W'(1);
                            if (n_q == 6'd0) spr0_q <= 1'b1;
                            if (last_spr) begin
                                state_q <= DONE;
                            end else begin
                                n_q        <= n_nxt;
                                oam_addr_q <= {n_nxt, 2'd0};
                                scan_ph_q  <= 1'b0;
                                state_q    <= full_next ? SCAN : FETCH_Y;
                            end
                        end
                    end
                    // Phase 0 waits for OAM data, phase 1 tests it.
                    SCAN: begin
                        scan_ph_q <= ~scan_ph_q;
                        if (scan_ph_q) begin
                            if (in_range) overflow_q <= 1'b1;
                            if (last_spr) begin
                                state_q <= DONE;
                            end else begin
                                n_q <= n_nxt;
`ifdef PPU_SPR_OVERFLOW_BUG_EN
                                if (!in_range) begin
                                    m_q        <= m_nxt;
                                    oam_addr_q <= {n_nxt, m_nxt};
                                end else begin
                                    oam_addr_q <= {n_nxt, m_q};
                                end
`else
                                oam_addr_q <= {n_nxt, 2'd0};
`endif
                            end
                        end
                    end
                    DONE: begin
                        if (x_i == 9'd0) state_q <= IDLE;
                    end
                    default: state_q <= IDLE;
                endcase
            end

            // Later assignments take priority: sprite-fetch reset, then CPU write.
            if (spr_enable_i && x_i >= 9'd257 && x_i <= 9'd320) oam_addr_q <= 8'd0;
            if (new_oam_addr_w_i) oam_addr_q <= new_oam_addr_i;
            if (y_i == 9'd261 && x_i == 9'd1) overflow_q <= 1'b0;
        end
    end

endmodule

// File: tb/tb_ppu_sprite_eval_n.sv
// Scoreboard bench for ppu_sprite_eval_n: directed scanlines, expectations stamped by (line, dot).
module tb_ppu_sprite_eval_n;

    localparam int K_CNT   = 0;
    localparam int K_OVF   = 1;
    localparam int K_SLOT0 = 2;
    localparam int K_SEC   = 3;
    localparam int K_ADDR  = 4;
    localparam int K_CNT16 = 5;
    localparam int K_OVF16 = 6;
    localparam int NONE    = -1;

    typedef struct {
        int    line;
        int    dot;
        int    kind;
        int    idx;
        int    exp;
        string name;
    } exp_t;

    logic       clk = 1'b0;
    logic       rst;
    logic [8:0] x_i, y_i;
    logic       spr_enable_i, spr_size16_i;
    logic [7:0] new_oam_addr_i;
    logic       new_oam_addr_w_i;

    logic [7:0] oam_addr, oam_data, sec_data;
    logic [4:0] sec_addr;
    logic       overflow, slot0;
    logic [3:0] sprite_count;

    logic [7:0] oam_addr16, oam_data16, sec_data16;
    logic [5:0] sec_addr16;
    logic       overflow16, slot016;
    logic [4:0] sprite_count16;

    logic [7:0] oam [256];
    exp_t       sb[$];
    int         line_no = -1;
    int         checks = 0;
    int         failures = 0;

    always #10 clk = ~clk;

    ppu_sprite_eval_n #(.MAX_SPRITES(8)) dut (
        .clk(clk), .rst(rst), .x_i(x_i), .y_i(y_i),
        .spr_enable_i(spr_enable_i), .spr_size16_i(spr_size16_i),
        .oam_addr_o(oam_addr), .oam_data_i(oam_data),
        .new_oam_addr_i(new_oam_addr_i), .new_oam_addr_w_i(new_oam_addr_w_i),
        .sec_oam_addr_i(sec_addr), .sec_oam_data_o(sec_data),
        .overflow_o(overflow), .slot_0_is_spr_0_o(slot0), .sprite_count_o(sprite_count)
    );

    ppu_sprite_eval_n #(.MAX_SPRITES(16)) dut16 (
        .clk(clk), .rst(rst), .x_i(x_i), .y_i(y_i),
        .spr_enable_i(spr_enable_i), .spr_size16_i(spr_size16_i),
        .oam_addr_o(oam_addr16), .oam_data_i(oam_data16),
        .new_oam_addr_i(new_oam_addr_i), .new_oam_addr_w_i(new_oam_addr_w_i),
        .sec_oam_addr_i(sec_addr16), .sec_oam_data_o(sec_data16),
        .overflow_o(overflow16), .slot_0_is_spr_0_o(slot016), .sprite_count_o(sprite_count16)
    );

    // Primary OAM: synchronous read, data one cycle after the address.
    always @(posedge clk) begin
        oam_data   <= oam[oam_addr];
        oam_data16 <= oam[oam_addr16];
    end

    task automatic chk(input int line, input int dot, input int kind, input int idx,
                       input int exp, input string name);
        exp_t e;
        e.line = line; e.dot = dot; e.kind = kind; e.idx = idx; e.exp = exp; e.name = name;
        sb.push_back(e);
    endtask

    task automatic oam_fill_ff();
        for (int i = 0; i < 256; i++) oam[i] = 8'hFF;
    endtask

    task automatic set_spr(input int n, input logic [7:0] y, input logic [7:0] t,
                           input logic [7:0] a, input logic [7:0] x);
        oam[n*4]   = y;
        oam[n*4+1] = t;
        oam[n*4+2] = a;
        oam[n*4+3] = x;
    endtask

    task automatic run_line(input int y, input int rst_lo, input int rst_hi,
                            input int drop_lo, input int drop_hi,
                            input int wr_dot, input logic [7:0] wr_val);
        line_no++;
        for (int x = 0; x < 341; x++) begin
            x_i              = 9'(x);
            y_i              = 9'(y);
            rst              = (x >= rst_lo && x <= rst_hi);
            spr_enable_i     = !(x >= drop_lo && x <= drop_hi);
            new_oam_addr_w_i = (x == wr_dot);
            new_oam_addr_i   = wr_val;
            @(posedge clk);
            #1;
        end
    endtask

    initial begin : monitor
        exp_t e;
        int   act;
        forever begin
            @(negedge clk);
            while (sb.size() > 0 && sb[0].line == line_no && sb[0].dot == int'(x_i)) begin
                e = sb.pop_front();
                if (e.kind == K_SEC) begin
                    sec_addr = 5'(e.idx);
                    #1;
                end
                case (e.kind)
                    K_CNT:   act = int'(sprite_count);
                    K_OVF:   act = int'(overflow);
                    K_SLOT0: act = int'(slot0);
                    K_SEC:   act = int'(sec_data);
                    K_ADDR:  act = int'(oam_addr);
                    K_CNT16: act = int'(sprite_count16);
                    default: act = int'(overflow16);
                endcase
                checks++;
                if (act !== e.exp) begin
                    failures++;
                    $display("FAIL %s line=%0d dot=%0d: got 0x%0h expected 0x%0h",
                             e.name, e.line, e.dot, act, e.exp);
                end
            end
        end
    end

    initial begin : driver
        rst = 1'b1; x_i = '0; y_i = '0; spr_enable_i = 1'b1; spr_size16_i = 1'b0;
        new_oam_addr_i = '0; new_oam_addr_w_i = 1'b0; sec_addr = '0; sec_addr16 = '0;
        oam_fill_ff();

        // Line 0: reset values.
        chk(0, 5, K_CNT,   0, 0,     "rst_count");
        chk(0, 5, K_OVF,   0, 0,     "rst_overflow");
        chk(0, 5, K_SLOT0, 0, 0,     "rst_slot0");
        chk(0, 5, K_ADDR,  0, 0,     "rst_oam_addr");
        chk(0, 5, K_CNT16, 0, 0,     "rst_count16");
        chk(0, 5, K_SEC,   0, 8'hFF, "rst_sec0");
        chk(0, 5, K_SEC,  31, 8'hFF, "rst_sec31");
        run_line(250, 0, 3, NONE, NONE, NONE, 8'h00);

        // Line 1: empty OAM.
        chk(1, 258, K_CNT,   0, 0,     "empty_count");
        chk(1, 258, K_OVF,   0, 0,     "empty_overflow");
        chk(1, 258, K_ADDR,  0, 0,     "empty_oam_addr");
        chk(1, 258, K_SEC,   0, 8'hFF, "empty_sec0");
        chk(1, 258, K_SEC,   3, 8'hFF, "empty_sec3");
        chk(1, 258, K_SEC,  31, 8'hFF, "empty_sec31");
        run_line(100, NONE, NONE - 1, NONE, NONE, NONE, 8'h00);

        // Line 2: sprite 0 copied into slot 0.
        set_spr(0, 8'd96, 8'h12, 8'h01, 8'd40);
        chk(2, 258, K_CNT,   0, 1,     "spr0_count");
        chk(2, 258, K_SLOT0, 0, 1,     "spr0_slot0");
        chk(2, 258, K_SEC,   0, 8'h60, "spr0_sec0");
        chk(2, 258, K_SEC,   1, 8'h12, "spr0_sec1");
        chk(2, 258, K_SEC,   2, 8'h01, "spr0_sec2");
        chk(2, 258, K_SEC,   3, 8'h28, "spr0_sec3");
        chk(2, 258, K_SEC,   4, 8'hFF, "spr0_sec4");
        chk(2, 258, K_OVF,   0, 0,     "spr0_overflow");
        run_line(100, NONE, NONE - 1, NONE, NONE, NONE, 8'h00);

        // Lines 3/4: sprite 5 at Y=90 on line 100, 8x8 then 8x16.
        oam_fill_ff();
        set_spr(5, 8'd90, 8'h33, 8'h02, 8'h10);
        chk(3, 258, K_CNT,   0, 0,     "h8_count");
        chk(3, 258, K_SLOT0, 0, 0,     "h8_slot0");
        chk(3, 258, K_SEC,   0, 8'hFF, "h8_sec0");
        run_line(100, NONE, NONE - 1, NONE, NONE, NONE, 8'h00);
        spr_size16_i = 1'b1;
        chk(4, 258, K_CNT,   0, 1,     "h16_count");
        chk(4, 258, K_SLOT0, 0, 0,     "h16_slot0");
        chk(4, 258, K_SEC,   0, 8'h5A, "h16_sec0");
        chk(4, 258, K_SEC,   1, 8'h33, "h16_sec1");
        run_line(100, NONE, NONE - 1, NONE, NONE, NONE, 8'h00);
        spr_size16_i = 1'b0;

        // Line 5: nine sprites on one line.
        oam_fill_ff();
        for (int k = 0; k < 9; k++) set_spr(k, 8'd50, 8'(8'h40 + k), 8'h00, 8'(k * 8));
        chk(5, 258, K_CNT,   0, 8,     "nine_count");
        chk(5, 258, K_OVF,   0, 1,     "nine_overflow");
        chk(5, 258, K_SLOT0, 0, 1,     "nine_slot0");
        chk(5, 258, K_SEC,  28, 8'h32, "nine_sec28");
        chk(5, 258, K_SEC,  29, 8'h47, "nine_sec29");
        chk(5, 258, K_CNT16, 0, 9,     "nine_count16");
        chk(5, 258, K_OVF16, 0, 0,     "nine_overflow16");
        run_line(55, NONE, NONE - 1, NONE, NONE, NONE, 8'h00);

        // Line 6: overflow sticky; line 7: cleared at line 261 dot 1.
        chk(6, 258, K_CNT,   0, 0,     "sticky_count");
        chk(6, 258, K_OVF,   0, 1,     "sticky_overflow");
        run_line(200, NONE, NONE - 1, NONE, NONE, NONE, 8'h00);
        chk(7, 1,   K_OVF,   0, 1,     "ovf_before_clear");
        chk(7, 2,   K_OVF,   0, 0,     "ovf_after_clear");
        run_line(261, NONE, NONE - 1, NONE, NONE, NONE, 8'h00);

        // Line 8: enable dropped at dot 120, CPU OAMADDR write at dot 300.
        oam_fill_ff();
        set_spr(0,  8'd96, 8'h12, 8'h01, 8'd40);
        set_spr(40, 8'd96, 8'h55, 8'h00, 8'h80);
        chk(8, 258, K_CNT,   0, 1,     "drop_count");
        chk(8, 258, K_SLOT0, 0, 1,     "drop_slot0");
        chk(8, 258, K_SEC,   0, 8'h60, "drop_sec0");
        chk(8, 258, K_SEC,   4, 8'hFF, "drop_sec4");
        chk(8, 301, K_ADDR,  0, 8'h24, "cpu_write_addr");
        chk(8, 302, K_ADDR,  0, 8'h00, "forced_addr_after_write");
        run_line(100, NONE, NONE - 1, 120, 249, 300, 8'h24);

        // Line 9: reset during COPY of sprite 0.
        chk(9, 70, K_CNT,    0, 0,     "midrst_count");
        chk(9, 70, K_SLOT0,  0, 0,     "midrst_slot0");
        chk(9, 70, K_OVF,    0, 0,     "midrst_overflow");
        chk(9, 70, K_ADDR,   0, 0,     "midrst_oam_addr");
        chk(9, 70, K_SEC,    0, 8'hFF, "midrst_sec0");
        chk(9, 70, K_SEC,    1, 8'hFF, "midrst_sec1");
        run_line(100, 69, 69, NONE, NONE, NONE, 8'h00);

        // Line 10: normal evaluation after reset.
        chk(10, 258, K_CNT,   0, 2,     "post_count");
        chk(10, 258, K_SLOT0, 0, 1,     "post_slot0");
        chk(10, 258, K_SEC,   4, 8'h60, "post_sec4");
        chk(10, 258, K_SEC,   5, 8'h55, "post_sec5");
        run_line(100, NONE, NONE - 1, NONE, NONE, NONE, 8'h00);

        repeat (4) @(posedge clk);
        if (sb.size() != 0) begin
            $display("FAIL unchecked_expectations: got %0d pending expected 0", sb.size());
            failures += sb.size();
        end
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
